// File: rtl/bsg_fifo_pkg.sv
// Shared helpers for the small FIFO controller: wrapping pointer increment and
// occupancy counter width.
package bsg_fifo_pkg;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned els);
    return (ptr + 1) % els;
  endfunction

  // Occupancy needs one extra bit so that a full FIFO (els entries) is representable.
  function automatic int unsigned count_width(input int unsigned els);
    return $clog2(els) + 1;
  endfunction

endpackage

// File: rtl/bsg_fifo_ptr_an.sv
// Wrapping FIFO pointer with async active-low reset and increment enable.
// Also exposes the next (incremented) value for full/empty look-ahead.
module bsg_fifo_ptr_an
  import bsg_fifo_pkg::*;
#(
  parameter int els_p = 2,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 inc_i,
  output logic [lg_els_lp-1:0] ptr_o,
  output logic [lg_els_lp-1:0] nxt_o
);

  logic [lg_els_lp-1:0] ptr_q, ptr_d;

  always_comb begin
    nxt_o = lg_els_lp'(ptr_inc(32'(ptr_q), els_p));
    ptr_d = inc_i ? nxt_o : ptr_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/bsg_mem_1r1w_synth.sv
// 1R1W register-array memory: synchronous write, asynchronous read.
// Writes are suppressed while w_reset_i is high; contents are never cleared.
module bsg_mem_1r1w_synth #(
  parameter int width_p = 1,
  parameter int els_p = 2,
  parameter int read_write_same_addr_p = 0,
  parameter int harden_p = 0,
  localparam int addr_width_lp = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  // Write-through bypass is only modelled for the soft array, and only when the
  // client allows same-address read/write in one cycle.
  localparam bit bypass_lp = (read_write_same_addr_p != 0) && (harden_p == 0);

  logic [width_p-1:0] mem_q [els_p];
  logic               we;

  assign we = w_v_i & ~w_reset_i;

  always_ff @(posedge w_clk_i) begin
    if (we) mem_q[w_addr_i] <= w_data_i;
  end

  always_comb begin
    r_data_o = '0;
    if (r_v_i) begin
      if (bypass_lp && we && (w_addr_i == r_addr_i)) r_data_o = w_data_i;
      else                                           r_data_o = mem_q[r_addr_i];
    end
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small_ctrl_an.sv
// Valid/ready-in, valid/yumi-out small FIFO: pointer/full/empty control around a
// 1R1W async-read memory. No bypass, so the memory never reads and writes one address together.
module bsg_fifo_1r1w_small_ctrl_an
  import bsg_fifo_pkg::*;
#(
  parameter int width_p = 26,
  parameter int els_p = 2,
  localparam int lg_els_lp = $clog2(els_p),
  localparam int cnt_w_lp = count_width(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                v_i,
  input  logic [width_p-1:0]  data_i,
  output logic                ready_o,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  input  logic                yumi_i,
  output logic [cnt_w_lp-1:0] count_o,
  output logic                err_o
);

  typedef logic [cnt_w_lp-1:0] count_t;

  logic [lg_els_lp-1:0] wptr, wptr_nxt, rptr, rptr_nxt, ptr_diff;
  logic full_q, full_d, empty_q, empty_d, err_q, err_d;
  logic enq, deq;

  assign ready_o = ~full_q;
  assign v_o     = ~empty_q;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign err_o   = err_q;

  bsg_fifo_ptr_an #(.els_p(els_p)) u_wptr (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .inc_i(enq), .ptr_o(wptr), .nxt_o(wptr_nxt)
  );

  bsg_fifo_ptr_an #(.els_p(els_p)) u_rptr (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .inc_i(deq), .ptr_o(rptr), .nxt_o(rptr_nxt)
  );

  always_comb begin
    full_d  = full_q;
    empty_d = empty_q;
    err_d   = err_q | (yumi_i & ~v_o);
    case ({enq, deq})
      2'b10: begin
        empty_d = 1'b0;
        full_d  = (wptr_nxt == rptr);
      end
      2'b01: begin
        full_d  = 1'b0;
        empty_d = (rptr_nxt == wptr);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  // Pointer difference wraps naturally because els_p is a power of two.
  always_comb begin
    ptr_diff = wptr - rptr;
    count_o  = full_q ? count_t'(els_p) : {1'b0, ptr_diff};
  end

  bsg_mem_1r1w_synth #(width_p, els_p, 0, 0) u_mem (
    .w_clk_i  (clk_i),
    .w_reset_i(~reset_n_i),
    .w_v_i    (enq),
    .w_addr_i (wptr),
    .w_data_i (data_i),
    .r_v_i    (v_o),
    .r_addr_i (rptr),
    .r_data_o (data_o)
  );

endmodule

// File: tb/tb_bsg_fifo_1r1w_small_ctrl_an.sv
// Scoreboard bench for bsg_fifo_1r1w_small_ctrl_an: stimulus pushes accepted words,
// a negedge monitor pops and compares on every dequeue.
module tb_bsg_fifo_1r1w_small_ctrl_an;

  localparam int W = 26;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          v_i, yumi_i;
  logic [W-1:0]  data_i;
  logic          ready_o, v_o, err_o;
  logic [W-1:0]  data_o;
  logic [1:0]    count_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  bsg_fifo_1r1w_small_ctrl_an #(.width_p(W), .els_p(2)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .count_o(count_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; the next edge applies them.
  task automatic step(input logic v, input logic [W-1:0] d, input logic y);
    v_i = v; data_i = d; yumi_i = y;
    if (v && ready_o && reset_n_i) exp_q.push_back(d);
    @(posedge clk_i); #1;
  endtask

  // Monitor: inputs and outputs are stable at the falling edge.
  always @(negedge clk_i) begin
    if (reset_n_i && v_o && yumi_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL deq_underflow: got %0h expected no dequeue", data_o);
      end else begin
        automatic logic [W-1:0] e = exp_q.pop_front();
        if (data_o !== e) begin
          errors++;
          $display("FAIL deq_data: got %0h expected %0h", data_o, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    check("rst_ready", ready_o, 1); check("rst_v", v_o, 0);
    check("rst_count", count_o, 0); check("rst_err", err_o, 0);

    // 1: reset mid-clock with two entries stored
    step(1, 26'h1, 0); step(1, 26'h2, 0);
    check("t1_count_full", count_o, 2);
    v_i = 0; #2;
    reset_n_i = 1'b0; #1;
    check("t1_ready", ready_o, 1); check("t1_v", v_o, 0);
    check("t1_count", count_o, 0); check("t1_err", err_o, 0);
    exp_q.delete();
    @(posedge clk_i); #1 reset_n_i = 1'b1;

    // 2: fill / drain
    step(1, 26'h0000AAA, 0); step(1, 26'h3FFFFFF, 0);
    check("t2_ready", ready_o, 0); check("t2_count", count_o, 2);
    step(0, 0, 1);
    check("t2_count1", count_o, 1);
    step(0, 0, 1);
    check("t2_v_empty", v_o, 0); check("t2_count0", count_o, 0);

    // 3: full + v_i + yumi_i blocks the enqueue
    step(1, 26'h11, 0); step(1, 26'h22, 0);
    step(1, 26'h33, 1);
    check("t3_count", count_o, 1); check("t3_ready", ready_o, 1);
    step(1, 26'h33, 0);
    check("t3_count2", count_o, 2);
    step(0, 0, 1); step(0, 0, 1);
    check("t3_empty", v_o, 0);

    // 4: steady stream at occupancy 1
    step(1, 26'h0, 0);
    for (int i = 1; i <= 10; i++) begin
      step(1, W'(i), 1);
      check("t4_count", count_o, 1);
    end
    step(0, 0, 1);
    check("t4_empty", v_o, 0);

    // 5: no fall-through when empty
    v_i = 1; data_i = 26'h123; yumi_i = 0;
    exp_q.push_back(26'h123);
    check("t5_same_cycle_v", v_o, 0);
    @(posedge clk_i); #1;
    check("t5_v", v_o, 1); check("t5_data", data_o, 26'h123);
    step(0, 0, 1);

    // 6: yumi on empty is sticky error, pointers unchanged
    step(0, 0, 1);
    check("t6_err", err_o, 1); check("t6_count", count_o, 0); check("t6_v", v_o, 0);
    step(1, 26'h55, 0);
    check("t6_count1", count_o, 1);
    step(0, 0, 1);
    check("t6_err_hold", err_o, 1); check("t6_count0", count_o, 0);
    reset_n_i = 1'b0; #1;
    check("t6_err_clr", err_o, 0);
    @(posedge clk_i); #1 reset_n_i = 1'b1;

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
